// File: rtl/rv_muldiv_unit_if.sv
// Core-side handshake bundle for the M-extension execute unit.
// The core drives the request fields and flush; the unit returns busy/done/result.
interface rv_muldiv_unit_if #(
  parameter int XLEN     = 32,
  parameter int FUNCT3_W = 3
);
  logic                start;
  logic [FUNCT3_W-1:0] funct3;
  logic [XLEN-1:0]     rs1_val;
  logic [XLEN-1:0]     rs2_val;
  logic                flush;
  logic                busy;
  logic                done;
  logic [XLEN-1:0]     result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output busy, done, result
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// RV32IM multiply/divide execute unit.
// Multiply takes one extra cycle after accept.
// Divide/remainder use a one-bit-per-cycle restoring divider on magnitudes, with a
// sign fix-up cycle.
// Divide-by-zero and signed overflow are resolved at the accept edge.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; result holds last value
// S_MUL  | operands latched, product formed and loaded next edge
// S_DIV  | restoring step per cycle, XLEN steps
// S_FIX  | apply quotient/remainder signs, load result
// S_DONE | done pulse; may accept a new op on this edge
module rv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FUNCT3_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rv_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  // Only funct3[1:0] matter once the path (MUL vs DIV) is chosen by the state.
  logic [1:0]       op_q, op_d;
  // a: multiplicand, or dividend shifting out MSB-first with quotient bits entering at LSB.
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  logic              in_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_abs, rs2_abs;
  logic              div_by_zero, div_ovf;
  logic              can_accept, accept;

  // Multiplier: sign/zero-extend both operands to 2*XLEN so one unsigned multiply
  // yields the correct low 2*XLEN bits for every signedness combination.
  always_comb begin
    mul_a_ext = {{XLEN{(op_q != 2'b11) & a_q[XLEN-1]}}, a_q};
    mul_b_ext = {{XLEN{(op_q[1] == 1'b0) & b_q[XLEN-1]}}, b_q};
    mul_prod  = mul_a_ext * mul_b_ext;
    mul_res   = (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // One restoring step plus the final sign fix-up.
  // The shifted partial remainder keeps its carry bit so divisors with the MSB set
  // still compare correctly.
  always_comb begin
    div_shift = {rem_q, a_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[XLEN-1:0] - b_q;
    quo_fix   = q_neg_q ? (~a_q + 1'b1) : a_q;
    rem_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Request decode at the accept edge: operand magnitudes and special-case detection.
  always_comb begin
    in_signed   = ~bus.funct3[0];
    rs1_neg     = in_signed & bus.rs1_val[XLEN-1];
    rs2_neg     = in_signed & bus.rs2_val[XLEN-1];
    rs1_abs     = rs1_neg ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
    rs2_abs     = rs2_neg ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
    div_by_zero = (bus.rs2_val == '0);
    div_ovf     = in_signed & (bus.rs1_val == INT_MIN) & (&bus.rs2_val);
    can_accept  = (state_q == S_IDLE) || (state_q == S_DONE);
    accept      = can_accept & bus.start & ~bus.flush;
  end

  // Next-state and datapath register updates; flush wins over start and completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d = bus.funct3[1:0];
          if (!bus.funct3[2]) begin
            a_d     = bus.rs1_val;
            b_d     = bus.rs2_val;
            state_d = S_MUL;
          end else if (div_by_zero) begin
            result_d = bus.funct3[1] ? bus.rs1_val : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = bus.funct3[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            a_d     = rs1_abs;
            b_d     = rs2_abs;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = rs1_neg ^ rs2_neg;
            r_neg_d = rs1_neg;
            state_d = S_DIV;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
      end

      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = div_ge ? div_sub : div_shift[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset mid-op discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign bus.busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: the driver pushes hand-computed results and
// the expected done cycle; a negedge monitor pops and compares on every done pulse.
module tb_rv_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
  localparam int LAT_MUL = 2, LAT_SPC = 1, LAT_DIV = 34;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   op_id;
  exp_t sb[$];

  rv_muldiv_unit_if #(.XLEN(32), .FUNCT3_W(3)) bus ();

  rv_muldiv_unit #(.XLEN(32), .FUNCT3_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, no op outstanding", bus.result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.res) begin
          errors++;
          $display("FAIL op%0d_result: got %h expected %h", e.id, bus.result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL op%0d_latency: done at cycle %0d expected %0d", e.id, cyc, e.cyc);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL op%0d_busy_at_done: busy=%b expected 0", e.id, bus.busy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.cyc = cyc + lat - 1;
    e.id  = op_id;
    op_id++;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within 100 cycles (busy=%b)", bus.busy);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    @(negedge clk);
    drive(f, a, b);
    @(posedge clk);
    #1;
    push_exp(exp, lat);
    bus.start = 1'b0;
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; op_id = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'b0, bus.busy}, 32'h0);
    check("reset_done",   {31'b0, bus.done}, 32'h0);
    check("reset_result", bus.result,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", {31'b0, bus.busy}, 32'h0);

    // Multiply variants
    issue(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
    issue(F_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, LAT_MUL);
    issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);
    issue(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
    issue(F_MUL,    32'd7,         32'd6,         32'h0000_002A, LAT_MUL);
    issue(F_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, LAT_MUL);

    // Divide normal cases, with a busy probe mid-divide
    @(negedge clk);
    drive(F_DIV, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk);
    #1;
    push_exp(32'hFFFF_FFFD, LAT_DIV);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("div_busy_mid", {31'b0, bus.busy}, 32'h1);
    wait_done();
    issue(F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_DIV);
    issue(F_DIVU, 32'd100,       32'd7,         32'd14,        LAT_DIV);
    issue(F_REMU, 32'd100,       32'd7,         32'd2,         LAT_DIV);
    issue(F_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         LAT_DIV);
    issue(F_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, LAT_DIV);
    issue(F_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_DIV);

    // Special cases resolve at the accept edge
    issue(F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPC);
    issue(F_REMU, 32'd5,         32'd0,         32'd5,         LAT_SPC);
    issue(F_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_SPC);
    issue(F_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SPC);
    issue(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC);
    issue(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPC);

    // Flush at divide iteration 10: no done, result keeps the previous value (0)
    @(negedge clk);
    drive(F_DIV, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy",   {31'b0, bus.busy}, 32'h0);
    check("flush_result", bus.result,        32'h0);
    repeat (40) @(negedge clk);
    check("flush_no_done_busy", {31'b0, bus.busy}, 32'h0);
    check("flush_result_later", bus.result,        32'h0);
    issue(F_MUL, 32'd3, 32'd4, 32'd12, LAT_MUL);

    // Async reset between clock edges in the middle of a divide
    @(negedge clk);
    drive(F_DIVU, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'b0, bus.busy}, 32'h0);
    check("async_rst_done",   {31'b0, bus.done}, 32'h0);
    check("async_rst_result", bus.result,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", {31'b0, bus.busy}, 32'h0);
    issue(F_DIVU, 32'd9, 32'd3, 32'd3, LAT_DIV);

    // Back-to-back: start held through DONE accepts the next op on that edge
    @(negedge clk);
    drive(F_MUL, 32'd7, 32'd6);
    @(posedge clk);
    #1;
    push_exp(32'h0000_002A, LAT_MUL);
    drive(F_DIVU, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    push_exp(32'd14, LAT_DIV);
    drive(F_MUL, 32'h1234_5678, 32'h10);
    wait_done();
    // second back-to-back hop: DIVU done -> MUL accepted on its DONE edge
    @(posedge clk);
    #1;
    push_exp(32'h2345_6780, LAT_MUL);
    bus.start = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d ops outstanding, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
